// File: rtl/axi_perf_pkg.sv
// Shared AXI encodings, response FSM states and the AR command entry for the read responder.
package axi_perf_pkg;

  localparam int MAX_ID_WIDTH = 16;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_DATA  = 2'd2
  } rsp_state_t;

  // id is sized for the widest supported ARID; narrower IDs are zero-extended.
  typedef struct packed {
    logic [MAX_ID_WIDTH-1:0] id;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ar_cmd_t;

  function automatic logic [2:0] max_arsize(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/rd_cmd_fifo.sv
// AR command queue: DEPTH entries (power of 2, >= 2), registered full/empty flags.
module rd_cmd_fifo
  import axi_perf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  ar_cmd_t din,
  input  logic    pop,
  output ar_cmd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  ar_cmd_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  // Push is qualified by the registered full flag only, so a pop in the same
  // cycle does not make room until the following cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_slave_rd_responder.sv
// AXI read-channel responder generating a counting data pattern with per-burst delay.
// Define RD_RESPONDER_ERR_INJECT_EN to return SLVERR on every beat of burst number err_burst.
module axi_slave_rd_responder
  import axi_perf_pkg::*;
#(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  start_pulse,
  input  logic [31:0]           init_data,
  input  logic [7:0]            rsp_delay,
  input  logic [31:0]           err_burst,
  output logic [31:0]           burst_count,
  output logic [39:0]           beat_count,
  output logic                  proto_error
);

  localparam int         WORDS    = DATA_WIDTH / 32;
  localparam logic [2:0] SIZE_MAX = max_arsize(DATA_WIDTH);

  rsp_state_t  state;
  rsp_state_t  state_next;
  ar_cmd_t     push_cmd;
  ar_cmd_t     head_cmd;
  ar_cmd_t     cur_cmd;
  logic        q_full;
  logic        q_empty;
  logic        q_pop;
  logic        ar_fire;
  logic        r_fire;
  logic        bad_req;
  logic        burst_err;
  logic [7:0]  dly_cnt;
  logic [7:0]  beat_idx;
  logic [39:0] idx;
  logic [31:0] word;
  logic        unused_ok;

  assign s_axi_arready = ~q_full & ~reset;
  assign ar_fire       = s_axi_arvalid & s_axi_arready;
  assign bad_req       = (s_axi_arburst != BURST_INCR) || (s_axi_arsize > SIZE_MAX);

  always_comb begin
    push_cmd                   = '0;
    push_cmd.id[ID_WIDTH-1:0]  = s_axi_arid;
    push_cmd.len               = s_axi_arlen;
    push_cmd.size              = s_axi_arsize;
    push_cmd.burst             = s_axi_arburst;
  end

  rd_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ar_fire),
    .din   (push_cmd),
    .pop   (q_pop),
    .dout  (head_cmd),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    state_next = state;
    q_pop      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          q_pop      = 1'b1;
          state_next = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (dly_cnt == 8'd0) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (r_fire && s_axi_rlast) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      dly_cnt  <= 8'd0;
      beat_idx <= 8'd0;
      cur_cmd  <= '0;
    end else begin
      state <= state_next;
      if (q_pop) begin
        cur_cmd  <= head_cmd;
        dly_cnt  <= rsp_delay;
        beat_idx <= 8'd0;
      end else if (state == ST_DELAY && dly_cnt != 8'd0) begin
        dly_cnt <= dly_cnt - 8'd1;
      end
      if (r_fire) beat_idx <= beat_idx + 8'd1;
    end
  end

  // Outputs are gated by the DATA state so they read zero in reset and between bursts;
  // every term only changes on a handshake, which keeps them stable under backpressure.
  assign s_axi_rvalid = (state == ST_DATA);
  assign r_fire       = s_axi_rvalid & s_axi_rready;
  assign s_axi_rlast  = s_axi_rvalid && (beat_idx == cur_cmd.len);
  assign s_axi_rid    = s_axi_rvalid ? cur_cmd.id[ID_WIDTH-1:0] : '0;
  assign word         = init_data + idx[31:0];
  assign s_axi_rdata  = s_axi_rvalid ? {WORDS{word}} : '0;
  assign s_axi_rresp  = (s_axi_rvalid && burst_err) ? RESP_SLVERR : RESP_OKAY;

`ifdef RD_RESPONDER_ERR_INJECT_EN
  // The burst in flight is number burst_count + 1 since the last start or reset.
  assign burst_err = (err_burst != 32'd0) && (err_burst == burst_count + 32'd1);
  assign unused_ok = ^{s_axi_araddr, cur_cmd.id, cur_cmd.size, cur_cmd.burst, idx[39:32]};
`else
  assign burst_err = 1'b0;
  assign unused_ok = ^{s_axi_araddr, cur_cmd.id, cur_cmd.size, cur_cmd.burst, idx[39:32], err_burst};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= 40'd0;
      beat_count  <= 40'd0;
      burst_count <= 32'd0;
      proto_error <= 1'b0;
    end else if (start_pulse) begin
      idx         <= 40'd0;
      beat_count  <= 40'd0;
      burst_count <= 32'd0;
      proto_error <= 1'b0;
    end else begin
      if (r_fire) begin
        idx        <= idx + 40'd1;
        beat_count <= beat_count + 40'd1;
        if (s_axi_rlast) burst_count <= burst_count + 32'd1;
      end
      if (ar_fire && bad_req) proto_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_slave_rd_responder.sv
// Directed self-checking bench for axi_slave_rd_responder (honours RD_RESPONDER_ERR_INJECT_EN).
module tb_axi_slave_rd_responder;
  import axi_perf_pkg::*;

  localparam int IDW = 4;
  localparam int AW  = 64;
  localparam int DW  = 512;

`ifdef RD_RESPONDER_ERR_INJECT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [IDW-1:0] s_axi_arid = '0;
  logic [AW-1:0]  s_axi_araddr = '0;
  logic [7:0]     s_axi_arlen = '0;
  logic [2:0]     s_axi_arsize = 3'd6;
  logic [1:0]     s_axi_arburst = BURST_INCR;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic           start_pulse = 1'b0;
  logic [31:0]    init_data = '0;
  logic [7:0]     rsp_delay = '0;
  logic [31:0]    err_burst = '0;
  logic [31:0]    burst_count;
  logic [39:0]    beat_count;
  logic           proto_error;

  int checks = 0;
  int errors = 0;

  axi_slave_rd_responder #(
    .ID_WIDTH   (IDW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CMD_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .start_pulse   (start_pulse),
    .init_data     (init_data),
    .rsp_delay     (rsp_delay),
    .err_burst     (err_burst),
    .burst_count   (burst_count),
    .beat_count    (beat_count),
    .proto_error   (proto_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [31:0] w);
    return {(DW/32){w}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1;
    step();
    start_pulse = 1'b0;
  endtask

  task automatic send_ar(input int id, input int len, input logic [1:0] burst);
    s_axi_arid    = IDW'(id);
    s_axi_arlen   = 8'(len);
    s_axi_arburst = burst;
    s_axi_arsize  = 3'd6;
    s_axi_araddr  = {$urandom, $urandom};
    s_axi_arvalid = 1'b1;
    check("ar_ready", s_axi_arready, 1'b1);
    step();
    s_axi_arvalid = 1'b0;
  endtask

  // n = edges after the accept edge until rvalid is seen; first rvalid cycle is T+1+n.
  task automatic wait_rvalid(output int n);
    n = 0;
    while (!s_axi_rvalid && n < 60) begin
      step();
      n++;
    end
    check("rvalid_timeout", s_axi_rvalid, 1'b1);
  endtask

  task automatic expect_beat(input string tag, input int id, input logic [31:0] w,
                             input bit last, input logic [1:0] resp);
    check({tag, "_valid"}, s_axi_rvalid, 1'b1);
    check({tag, "_id"}, s_axi_rid, IDW'(id));
    check({tag, "_data"}, s_axi_rdata, rep(w));
    check({tag, "_last"}, s_axi_rlast, last);
    check({tag, "_resp"}, s_axi_rresp, resp);
    step();
  endtask

  initial begin
    int n;
    int beats;
    int got;
    int hs_at;
    int acc_at;
    bit tog;
    bit prev_stall;
    bit hs;
    bit acc;

    // reset state
    step();
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_rdata", s_axi_rdata, '0);
    check("rst_counts", {burst_count, beat_count, proto_error}, '0);
    reset = 1'b0;
    step();

    // single burst, zero delay
    init_data = 32'h100; rsp_delay = 8'd0; s_axi_rready = 1'b1;
    send_ar(1, 3, BURST_INCR);
    wait_rvalid(n);
    check("t1_first_rvalid_cycle", n + 1, 3);
    for (int k = 0; k < 4; k++) expect_beat("t1_beat", 1, 32'h100 + k, k == 3, RESP_OKAY);
    check("t1_beat_count", beat_count, 40'd4);
    check("t1_burst_count", burst_count, 32'd1);
    check("t1_idle", s_axi_rvalid, 1'b0);

    // backpressure: rready alternates 1/0
    pulse_start();
    check("t2_cleared", beat_count, 40'd0);
    init_data = 32'h200; s_axi_rready = 1'b0;
    send_ar(2, 7, BURST_INCR);
    beats = 0; tog = 1'b1; prev_stall = 1'b0;
    for (int i = 0; i < 80 && beats < 8; i++) begin
      s_axi_rready = tog;
      tog = ~tog;
      if (s_axi_rvalid) begin
        check("t2_data", s_axi_rdata, rep(32'h200 + beats));
        check("t2_id", s_axi_rid, IDW'(2));
        check("t2_last", s_axi_rlast, beats == 7);
        prev_stall = !s_axi_rready;
        if (s_axi_rready) beats++;
      end else if (prev_stall) begin
        check("t2_valid_held", s_axi_rvalid, 1'b1);
        prev_stall = 1'b0;
      end
      step();
    end
    s_axi_rready = 1'b1;
    check("t2_beats_seen", beats, 8);
    check("t2_beat_count", beat_count, 40'd8);
    check("t2_burst_count", burst_count, 32'd1);

    // queue full: first AR goes straight into the FSM, four more fill the queue
    pulse_start();
    s_axi_rready = 1'b0;
    for (int id = 0; id < 5; id++) send_ar(id, 0, BURST_INCR);
    s_axi_arid = IDW'(5); s_axi_arlen = 8'd0; s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    check("t3_full_arready", s_axi_arready, 1'b0);
    step();
    check("t3_full_held", s_axi_arready, 1'b0);
    s_axi_rready = 1'b1;
    got = 0; hs_at = -100; acc_at = -1;
    for (int i = 0; i < 100 && got < 6; i++) begin
      hs  = s_axi_rvalid && s_axi_rready;
      acc = s_axi_arvalid && s_axi_arready;
      if (hs) begin
        check("t3_order", s_axi_rid, IDW'(got));
        check("t3_last", s_axi_rlast, 1'b1);
        if (got == 0) hs_at = i;
        got++;
      end
      if (acc) acc_at = i;
      step();
      if (acc) s_axi_arvalid = 1'b0;
    end
    s_axi_arvalid = 1'b0;
    check("t3_bursts", got, 6);
    check("t3_slot_free_delay", acc_at - hs_at, 2);

    // response delay with 32-bit pattern wrap
    pulse_start();
    rsp_delay = 8'd5; init_data = 32'hFFFF_FFFE;
    send_ar(3, 3, BURST_INCR);
    wait_rvalid(n);
    check("t4_first_rvalid_cycle", n + 1, 8);
    expect_beat("t4_b0", 3, 32'hFFFF_FFFE, 1'b0, RESP_OKAY);
    expect_beat("t4_b1", 3, 32'hFFFF_FFFF, 1'b0, RESP_OKAY);
    expect_beat("t4_b2", 3, 32'h0000_0000, 1'b0, RESP_OKAY);
    expect_beat("t4_b3", 3, 32'h0000_0001, 1'b1, RESP_OKAY);

    // protocol error, then start_pulse on a beat handshake
    pulse_start();
    rsp_delay = 8'd0; init_data = 32'h500;
    check("t5_perr_clear", proto_error, 1'b0);
    send_ar(0, 1, 2'b10);
    check("t5_perr_set", proto_error, 1'b1);
    wait_rvalid(n);
    expect_beat("t5_wrap_b0", 0, 32'h500, 1'b0, RESP_OKAY);
    expect_beat("t5_wrap_b1", 0, 32'h501, 1'b1, RESP_OKAY);
    send_ar(2, 3, BURST_INCR);
    wait_rvalid(n);
    expect_beat("t5_b0", 2, 32'h502, 1'b0, RESP_OKAY);
    start_pulse = 1'b1;
    expect_beat("t5_b1", 2, 32'h503, 1'b0, RESP_OKAY);
    start_pulse = 1'b0;
    check("t5_start_beats", beat_count, 40'd0);
    check("t5_start_bursts", burst_count, 32'd0);
    check("t5_start_perr", proto_error, 1'b0);
    expect_beat("t5_b2", 2, 32'h500, 1'b0, RESP_OKAY);
    expect_beat("t5_b3", 2, 32'h501, 1'b1, RESP_OKAY);
    check("t5_beat_count", beat_count, 40'd2);
    check("t5_burst_count", burst_count, 32'd1);

    // error injection on burst 2 (OKAY everywhere when the feature is compiled out)
    pulse_start();
    err_burst = 32'd2; init_data = 32'h600;
    for (int b = 0; b < 3; b++) begin
      send_ar(b, 1, BURST_INCR);
      wait_rvalid(n);
      expect_beat("t6_b0", b, 32'h600 + 2 * b, 1'b0,
                  (ERR_EN && b == 1) ? RESP_SLVERR : RESP_OKAY);
      expect_beat("t6_b1", b, 32'h601 + 2 * b, 1'b1,
                  (ERR_EN && b == 1) ? RESP_SLVERR : RESP_OKAY);
    end
    check("t6_burst_count", burst_count, 32'd3);
    err_burst = 32'd0;

    // reset mid-burst
    s_axi_rready = 1'b0;
    send_ar(1, 7, BURST_INCR);
    wait_rvalid(n);
    #1 reset = 1'b1;
    #1;
    check("t7_rvalid", s_axi_rvalid, 1'b0);
    check("t7_rlast", s_axi_rlast, 1'b0);
    check("t7_rid", s_axi_rid, '0);
    check("t7_rresp", s_axi_rresp, 2'b00);
    check("t7_rdata", s_axi_rdata, '0);
    check("t7_arready", s_axi_arready, 1'b0);
    check("t7_counts", {burst_count, beat_count, proto_error}, '0);
    step();
    reset = 1'b0;
    step();
    init_data = 32'h700; s_axi_rready = 1'b1;
    send_ar(1, 0, BURST_INCR);
    wait_rvalid(n);
    expect_beat("t7_after", 1, 32'h700, 1'b1, RESP_OKAY);
    check("t7_burst_count", burst_count, 32'd1);
    check("t7_beat_count", beat_count, 40'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
